bus_memory_responder: RTL and testbench

Responder end of the core's memory bus. It accepts memory_read/memory_write strobes with a byte address and write data from the core, and returns read data one cycle later. It maps a word-wide on-chip RAM at address 0 and a small MMIO register block (GPIO out, GPIO in, cycle counter, status) at MMIO_BASE. It flags misaligned and unmapped accesses.

---
 rtl/bus_memory_responder.sv | 116 +++++++++++
 tb/tb_bus_memory_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// Responder end of the core's memory bus: word-wide on-chip RAM at address 0
// and a 16-byte MMIO block (GPIO out, GPIO in, cycle counter, status) at
// MMIO_BASE. Read data and the fault pulse are registered, giving a fixed
// one-cycle latency with no stall.
module bus_memory_responder #(
  parameter int unsigned MEMORY_SIZE = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h80000000,
  parameter int unsigned GPIO_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_read,
  input  logic                  memory_write,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  access_fault,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in
);

  localparam int unsigned WORDS = MEMORY_SIZE / 4;
  localparam int unsigned AW    = $clog2(MEMORY_SIZE);

  logic [31:0]           mem [WORDS];
  logic [GPIO_WIDTH-1:0] gpio_out_q;
  logic [GPIO_WIDTH-1:0] gpio_sync1;
  logic [GPIO_WIDTH-1:0] gpio_sync2;
  logic [31:0]           cycle_count;
  logic                  sticky_fault;

  logic                  strobe;
  logic                  ram_hit;
  logic                  mmio_hit;
  logic                  misaligned;
  logic                  fault;
  logic                  ram_write;
  logic                  mmio_write;
  logic [AW-3:0]         word_index;
  logic [1:0]            mmio_sel;

  logic [GPIO_WIDTH-1:0] gpio_next;
  logic [31:0]           cycle_next;
  logic                  sticky_next;
  logic [31:0]           ram_rdata;
  logic [31:0]           mmio_rdata;

  // Address decode and fault detection; RAM wins if the regions ever overlap.
  always_comb begin
    strobe     = memory_read | memory_write;
    ram_hit    = address < 32'(MEMORY_SIZE);
    mmio_hit   = (address[31:4] == MMIO_BASE[31:4]) && !ram_hit;
    misaligned = address[1:0] != 2'b00;
    fault      = strobe && (misaligned || !(ram_hit || mmio_hit));
    ram_write  = memory_write && !fault && ram_hit;
    mmio_write = memory_write && !fault && mmio_hit;
    word_index = address[AW-1:2];
    mmio_sel   = address[3:2];
  end

  // Next register values and write-first read mux for the MMIO block.
  always_comb begin
    gpio_next = gpio_out_q;
    if (mmio_write && mmio_sel == 2'd0) gpio_next = write_data[GPIO_WIDTH-1:0];

    cycle_next = cycle_count + 32'd1;
    if (mmio_write && mmio_sel == 2'd2) cycle_next = '0;

    sticky_next = sticky_fault;
    if (mmio_write && mmio_sel == 2'd3 && write_data[0]) sticky_next = 1'b0;
    if (fault) sticky_next = 1'b1;

    mmio_rdata = '0;
    case (mmio_sel)
      2'd0: mmio_rdata[GPIO_WIDTH-1:0] = gpio_next;
      2'd1: mmio_rdata[GPIO_WIDTH-1:0] = gpio_sync2;
      2'd2: mmio_rdata = (mmio_write) ? 32'd0 : cycle_count;
      default: mmio_rdata[0] = sticky_next;
    endcase

    ram_rdata = memory_write ? write_data : mem[word_index];
  end

  // RAM array: not cleared by reset, and reset blocks any write in its cycle.
  always_ff @(posedge clk) begin
    if (!reset && ram_write) mem[word_index] <= write_data;
  end

  // Registered outputs, MMIO registers, counter and gpio_in synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data    <= '0;
      access_fault <= 1'b0;
      gpio_out_q   <= '0;
      gpio_sync1   <= '0;
      gpio_sync2   <= '0;
      cycle_count  <= '0;
      sticky_fault <= 1'b0;
    end else begin
      gpio_sync1   <= gpio_in;
      gpio_sync2   <= gpio_sync1;
      gpio_out_q   <= gpio_next;
      cycle_count  <= cycle_next;
      sticky_fault <= sticky_next;
      access_fault <= fault;
      if (memory_read) begin
        if (fault)        read_data <= '0;
        else if (ram_hit) read_data <= ram_rdata;
        else              read_data <= mmio_rdata;
      end
    end
  end

  assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed testbench for bus_memory_responder: RAM, MMIO, faults, counter, reset.
module tb_bus_memory_responder;

  localparam logic [31:0] MMIO = 32'h80000000;

  logic        clk;
  logic        reset;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        access_fault;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in;

  int compared;
  int mismatched;

  bus_memory_responder #(
    .MEMORY_SIZE(4096),
    .MMIO_BASE  (MMIO),
    .GPIO_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memory_read (memory_read),
    .memory_write(memory_write),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .access_fault(access_fault),
    .gpio_out    (gpio_out),
    .gpio_in     (gpio_in)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bus cycle, advance past the edge, then drop the strobes.
  task automatic bus_cycle(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data);
    memory_read  = rd;
    memory_write = wr;
    address      = addr;
    write_data   = data;
    @(posedge clk);
    #1;
    memory_read  = 1'b0;
    memory_write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    compared++;
    if (read_data !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_read_data got=%h want=%h", read_data, 32'h0);
    end
    compared++;
    if (access_fault !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_access_fault got=%b want=0", access_fault);
    end
    compared++;
    if (gpio_out !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_gpio_out got=%h want=00", gpio_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_ram_readback;
    bus_cycle(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    compared++;
    if (access_fault !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ram_write_fault got=%b want=0", access_fault);
    end
    bus_cycle(1'b1, 1'b0, 32'h10, 32'h0);
    compared++;
    if (read_data !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL ram_readback got=%h want=DEADBEEF", read_data);
    end
    compared++;
    if (access_fault !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ram_read_fault got=%b want=0", access_fault);
    end
  endtask

  task automatic test_write_first;
    bus_cycle(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA);
    bus_cycle(1'b1, 1'b1, 32'h20, 32'h12345678);
    compared++;
    if (read_data !== 32'h12345678) begin
      mismatched++;
      $display("[TB] FAIL write_first got=%h want=12345678", read_data);
    end
    bus_cycle(1'b1, 1'b0, 32'h20, 32'h0);
    compared++;
    if (read_data !== 32'h12345678) begin
      mismatched++;
      $display("[TB] FAIL write_first_stored got=%h want=12345678", read_data);
    end
  endtask

  task automatic test_gpio;
    bus_cycle(1'b0, 1'b1, MMIO, 32'hFFFFFFA5);
    compared++;
    if (gpio_out !== 8'hA5) begin
      mismatched++;
      $display("[TB] FAIL gpio_out got=%h want=A5", gpio_out);
    end
    bus_cycle(1'b1, 1'b0, MMIO, 32'h0);
    compared++;
    if (read_data !== 32'h000000A5) begin
      mismatched++;
      $display("[TB] FAIL gpio_out_readback got=%h want=000000A5", read_data);
    end
    gpio_in = 8'h3C;
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    bus_cycle(1'b1, 1'b0, MMIO + 32'h4, 32'h0);
    compared++;
    if (read_data !== 32'h0000003C) begin
      mismatched++;
      $display("[TB] FAIL gpio_in_read got=%h want=0000003C", read_data);
    end
    bus_cycle(1'b0, 1'b1, MMIO + 32'h4, 32'hFFFFFFFF);
    compared++;
    if (access_fault !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL gpio_in_write_fault got=%b want=0", access_fault);
    end
  endtask

  task automatic test_faults;
    bus_cycle(1'b1, 1'b0, 32'h13, 32'h0);
    compared++;
    if (read_data !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL misaligned_read_data got=%h want=00000000", read_data);
    end
    compared++;
    if (access_fault !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL misaligned_fault got=%b want=1", access_fault);
    end
    bus_cycle(1'b1, 1'b0, MMIO + 32'hC, 32'h0);
    compared++;
    if (access_fault !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fault_pulse_width got=%b want=0", access_fault);
    end
    compared++;
    if (read_data !== 32'h1) begin
      mismatched++;
      $display("[TB] FAIL status_sticky got=%h want=00000001", read_data);
    end
    bus_cycle(1'b0, 1'b1, MMIO + 32'hC, 32'h1);
    bus_cycle(1'b1, 1'b0, MMIO + 32'hC, 32'h0);
    compared++;
    if (read_data !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL status_clear got=%h want=00000000", read_data);
    end
    bus_cycle(1'b0, 1'b1, 32'h0, 32'h11111111);
    bus_cycle(1'b0, 1'b1, 32'h40000000, 32'h55555555);
    compared++;
    if (access_fault !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL unmapped_fault got=%b want=1", access_fault);
    end
    bus_cycle(1'b0, 1'b1, 32'h11, 32'h77777777);
    compared++;
    if (access_fault !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL misaligned_write_fault got=%b want=1", access_fault);
    end
    bus_cycle(1'b1, 1'b0, 32'h0, 32'h0);
    compared++;
    if (read_data !== 32'h11111111) begin
      mismatched++;
      $display("[TB] FAIL unmapped_write_suppressed got=%h want=11111111", read_data);
    end
    bus_cycle(1'b1, 1'b0, 32'h10, 32'h0);
    compared++;
    if (read_data !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL misaligned_write_suppressed got=%h want=DEADBEEF", read_data);
    end
    bus_cycle(1'b1, 1'b0, MMIO + 32'hC, 32'h0);
    compared++;
    if (read_data !== 32'h1) begin
      mismatched++;
      $display("[TB] FAIL status_resticky got=%h want=00000001", read_data);
    end
  endtask

  task automatic test_cycle;
    bus_cycle(1'b0, 1'b1, MMIO + 32'h8, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    bus_cycle(1'b1, 1'b0, MMIO + 32'h8, 32'h0);
    compared++;
    if (read_data !== 32'd5) begin
      mismatched++;
      $display("[TB] FAIL cycle_count got=%0d want=5", read_data);
    end
    dut.cycle_count = 32'hFFFFFFFF;
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    bus_cycle(1'b1, 1'b0, MMIO + 32'h8, 32'h0);
    compared++;
    if (read_data !== 32'd1) begin
      mismatched++;
      $display("[TB] FAIL cycle_wrap got=%h want=00000001", read_data);
    end
    bus_cycle(1'b1, 1'b1, MMIO + 32'h8, 32'h12345678);
    compared++;
    if (read_data !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL cycle_write_first got=%h want=00000000", read_data);
    end
  endtask

  task automatic test_back_to_back;
    bus_cycle(1'b0, 1'b1, 32'h100, 32'h00000001);
    bus_cycle(1'b0, 1'b1, 32'h104, 32'h00000002);
    bus_cycle(1'b1, 1'b0, 32'h100, 32'h0);
    compared++;
    if (read_data !== 32'h1) begin
      mismatched++;
      $display("[TB] FAIL b2b_read0 got=%h want=00000001", read_data);
    end
    bus_cycle(1'b1, 1'b0, 32'h104, 32'h0);
    compared++;
    if (read_data !== 32'h2) begin
      mismatched++;
      $display("[TB] FAIL b2b_read1 got=%h want=00000002", read_data);
    end
  endtask

  task automatic test_reset_priority;
    bus_cycle(1'b0, 1'b1, MMIO, 32'h000000A5);
    bus_cycle(1'b1, 1'b0, 32'h17, 32'h0);
    reset = 1'b1;
    bus_cycle(1'b0, 1'b1, 32'h10, 32'h0);
    compared++;
    if (gpio_out !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL rst_gpio_out got=%h want=00", gpio_out);
    end
    compared++;
    if (read_data !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rst_read_data got=%h want=00000000", read_data);
    end
    compared++;
    if (access_fault !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_access_fault got=%b want=0", access_fault);
    end
    compared++;
    if (dut.cycle_count !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rst_cycle_count got=%h want=00000000", dut.cycle_count);
    end
    reset = 1'b0;
    bus_cycle(1'b1, 1'b0, 32'h10, 32'h0);
    compared++;
    if (read_data !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL rst_ram_kept got=%h want=DEADBEEF", read_data);
    end
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b1;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    address      = 32'h0;
    write_data   = 32'h0;
    gpio_in      = 8'h00;
    test_reset();
    test_ram_readback();
    test_write_first();
    test_gpio();
    test_faults();
    test_cycle();
    test_back_to_back();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
